shift_register_universal: RTL and testbench



---
 rtl/shift_register_universal.sv | 107 ++++++++++
 tb/tb_shift_register_universal.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/shift_register_universal.sv
// Universal shift register: load, bidirectional shift, rotate, arithmetic shift, clear,
// plus a frame counter that pulses word_ready every WIDTH shifts. Define SHADOW_EN to add word_out.
module shift_register_universal #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [2:0]               mode,
    input  logic                     serial_in_left,
    input  logic                     serial_in_right,
    input  logic [WIDTH-1:0]         parallel_in,
    output logic [WIDTH-1:0]         q,
    output logic                     serial_out_left,
    output logic                     serial_out_right,
    output logic [$clog2(WIDTH)-1:0] count,
`ifdef SHADOW_EN
    output logic [WIDTH-1:0]         word_out,
`endif
    output logic                     word_ready
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_SHR   = 3'b001,
        M_SHL   = 3'b010,
        M_LOAD  = 3'b011,
        M_ROTR  = 3'b100,
        M_ROTL  = 3'b101,
        M_CLEAR = 3'b110,
        M_ASR   = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic             word_ready_q, word_ready_d;
    logic             counting;

    always_comb begin
        q_d          = q_q;
        count_d      = count_q;
        word_ready_d = 1'b0;
        counting     = 1'b0;
        if (enable) begin
            case (mode_e'(mode))
                M_HOLD:  ;
                M_SHR:   begin q_d = {serial_in_left, q_q[WIDTH-1:1]};  counting = 1'b1; end
                M_SHL:   begin q_d = {q_q[WIDTH-2:0], serial_in_right}; counting = 1'b1; end
                M_LOAD:  begin q_d = parallel_in;                       count_d = '0;    end
                M_ROTR:  begin q_d = {q_q[0], q_q[WIDTH-1:1]};          counting = 1'b1; end
                M_ROTL:  begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};    counting = 1'b1; end
                M_CLEAR: begin q_d = '0;                                count_d = '0;    end
                M_ASR:   begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};    counting = 1'b1; end
                default: ;
            endcase
            // Every shift-type op advances the frame; wrapping marks a complete word.
            if (counting) begin
                if (count_q == LAST) begin
                    count_d      = '0;
                    word_ready_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q          <= RESET_VALUE;
            count_q      <= '0;
            word_ready_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            count_q      <= count_d;
            word_ready_q <= word_ready_d;
        end
    end

`ifdef SHADOW_EN
    logic [WIDTH-1:0] word_out_q, word_out_d;

    // Captures the completed word so it stays stable while the next frame shifts in.
    always_comb begin
        word_out_d = word_out_q;
        if (word_ready_d) word_out_d = q_d;
    end

    always_ff @(posedge clock) begin
        if (reset) word_out_q <= '0;
        else       word_out_q <= word_out_d;
    end

    assign word_out = word_out_q;
`endif

    assign q                = q_q;
    assign count            = count_q;
    assign word_ready       = word_ready_q;
    assign serial_out_left  = q_q[WIDTH-1];
    assign serial_out_right = q_q[0];

endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal (WIDTH=4): directed plan steps plus random ops,
// checked against an arithmetic reference model.
module tb_shift_register_universal;

  localparam int W   = 4;
  localparam int MSB = 1 << (W - 1);
  localparam int MOD = 1 << W;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [2:0]       mode = 3'b000;
  logic             serial_in_left = 1'b0;
  logic             serial_in_right = 1'b0;
  logic [W-1:0]     parallel_in = '0;
  logic [W-1:0]     q;
  logic             serial_out_left;
  logic             serial_out_right;
  logic [$clog2(W)-1:0] count;
  logic             word_ready;
`ifdef SHADOW_EN
  logic [W-1:0]     word_out;
`endif

  shift_register_universal #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .serial_in_left(serial_in_left),
    .serial_in_right(serial_in_right),
    .parallel_in(parallel_in),
    .q(q),
    .serial_out_left(serial_out_left),
    .serial_out_right(serial_out_right),
    .count(count),
`ifdef SHADOW_EN
    .word_out(word_out),
`endif
    .word_ready(word_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: register value as an integer, shifts counted per frame.
  int   m_q   = 0;
  int   m_cnt = 0;
  logic m_rdy = 1'b0;
  int   m_wo  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("q", 32'(q), 32'(m_q));
    chk("count", 32'(count), 32'(m_cnt));
    chk("word_ready", 32'(word_ready), 32'(m_rdy));
    chk("serial_out_left", 32'(serial_out_left), 32'(m_q / MSB));
    chk("serial_out_right", 32'(serial_out_right), 32'(m_q % 2));
`ifdef SHADOW_EN
    chk("word_out", 32'(word_out), 32'(m_wo));
`endif
  endtask

  // Drive one edge worth of inputs, advance the model, then compare on the falling edge.
  task automatic step(input logic rst, input logic en, input logic [2:0] md,
                      input logic sil, input logic sir, input logic [W-1:0] pin);
    bit shifts;
    reset = rst; enable = en; mode = md;
    serial_in_left = sil; serial_in_right = sir; parallel_in = pin;
    @(posedge clock);
    shifts = 1'b0;
    if (rst) begin
      m_q = 0; m_cnt = 0; m_rdy = 1'b0; m_wo = 0;
    end else if (!en) begin
      m_rdy = 1'b0;
    end else begin
      case (md)
        3'd1: begin m_q = m_q / 2 + (sil ? MSB : 0);               shifts = 1'b1; end
        3'd2: begin m_q = (m_q * 2 + int'(sir)) % MOD;             shifts = 1'b1; end
        3'd3: begin m_q = int'(pin); m_cnt = 0;                                   end
        3'd4: begin m_q = m_q / 2 + (m_q % 2) * MSB;               shifts = 1'b1; end
        3'd5: begin m_q = (m_q * 2) % MOD + m_q / MSB;             shifts = 1'b1; end
        3'd6: begin m_q = 0; m_cnt = 0;                                           end
        3'd7: begin m_q = m_q / 2 + (m_q >= MSB ? MSB : 0);        shifts = 1'b1; end
        default: ;
      endcase
      m_rdy = 1'b0;
      if (shifts) begin
        m_cnt++;
        if (m_cnt == W) begin
          m_cnt = 0; m_rdy = 1'b1; m_wo = m_q;
        end
      end
    end
    @(negedge clock);
    check_all();
  endtask

  initial begin
    logic [3:0] bits;
    @(negedge clock);

    // Reset, load 1011, then reset must beat a simultaneous load.
    step(1, 0, 3'd0, 0, 0, 4'h0);
    step(0, 1, 3'd3, 0, 0, 4'b1011);
    chk("pre_reset_q", 32'(q), 32'b1011);
    step(1, 1, 3'd3, 0, 0, 4'b1111);
    chk("reset_over_load", 32'(q), 32'b0000);

    // Serial-in from the left: 1,0,1,1 becomes 1101 with a pulse on the 4th edge only.
    bits = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      step(0, 1, 3'd1, bits[i == 3 ? 0 : (i == 2 ? 1 : (i == 1 ? 2 : 3))], 0, 4'h0);
      chk("serial_ready", 32'(word_ready), 32'(i == 0));
    end
    chk("serial_word", 32'(q), 32'b1101);
    chk("serial_count", 32'(count), 32'd0);

    // Rotates.
    step(0, 1, 3'd3, 0, 0, 4'b1001);
    step(0, 1, 3'd5, 0, 0, 4'h0);
    chk("rotl", 32'(q), 32'b0011);
    chk("rotl_count", 32'(count), 32'd1);
    step(0, 1, 3'd3, 0, 0, 4'b1001);
    step(0, 1, 3'd4, 0, 0, 4'h0);
    chk("rotr", 32'(q), 32'b1100);

    // Arithmetic shift keeps the sign bit.
    step(0, 1, 3'd3, 0, 0, 4'b1000);
    step(0, 1, 3'd7, 0, 0, 4'h0);
    chk("asr1", 32'(q), 32'b1100);
    step(0, 1, 3'd7, 0, 0, 4'h0);
    chk("asr2", 32'(q), 32'b1110);
    chk("asr_sol", 32'(serial_out_left), 32'd1);

    // Hold with enable low, then a mid-frame load restarts the frame.
    step(0, 1, 3'd6, 0, 0, 4'h0);
    step(0, 1, 3'd1, 1, 0, 4'h0);
    step(0, 1, 3'd1, 0, 0, 4'h0);
    chk("pre_hold_count", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd1, 1, 1, 4'hF);
    chk("hold_count", 32'(count), 32'd2);
    step(0, 1, 3'd3, 0, 0, 4'b0110);
    chk("load_count", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 3'd1, 1'($urandom_range(0, 1)), 0, 4'h0);
      chk("after_load_ready", 32'(word_ready), 32'(i == 3));
    end

    // Continuous left stream: pulses after edges 4, 8, 12.
    step(0, 1, 3'd6, 0, 0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 3'd2, 0, 1'($urandom_range(0, 1)), 4'h0);
      chk("stream_ready", 32'(word_ready), 32'((i % 4) == 3));
    end

    // Random operations against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 7) != 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
